// File: rtl/fp_add_sequencer_pkg.sv
// Shared float helpers and sequencer state encoding for the adder issue/capture controller.
package fp_add_sequencer_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exponent;
        logic [22:0] mantissa;
    } float_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_DONE
    } seq_state_t;

    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;

    function automatic logic fp_is_nan(input float_t f);
        return (f.exponent == FP_EXP_MAX) && (f.mantissa != '0);
    endfunction

    function automatic logic fp_is_inf(input float_t f);
        return (f.exponent == FP_EXP_MAX) && (f.mantissa == '0);
    endfunction

endpackage

// File: rtl/fp_special_resolve.sv
// Combinational NaN/Inf resolution: decides whether an operand pair can skip the adder
// and, if so, what the result and flags are.
module fp_special_resolve (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        bypass,
    output logic [31:0] result,
    output logic        res_inf,
    output logic        res_nan
);
    import fp_add_sequencer_pkg::*;

    logic a_nan, b_nan, a_inf, b_inf;

    assign a_nan = fp_is_nan(a);
    assign b_nan = fp_is_nan(b);
    assign a_inf = fp_is_inf(a);
    assign b_inf = fp_is_inf(b);

    always_comb begin
        bypass  = 1'b0;
        result  = '0;
        res_inf = 1'b0;
        res_nan = 1'b0;
        if (a_nan || b_nan) begin
            bypass  = 1'b1;
            result  = FP_QNAN;
            res_nan = 1'b1;
        end else if (a_inf && b_inf) begin
            bypass = 1'b1;
            // Opposite infinities have no defined sum
            if (a[31] == b[31]) begin
                result  = a;
                res_inf = 1'b1;
            end else begin
                result  = FP_QNAN;
                res_nan = 1'b1;
            end
        end else if (a_inf) begin
            bypass  = 1'b1;
            result  = a;
            res_inf = 1'b1;
        end else if (b_inf) begin
            bypass  = 1'b1;
            result  = b;
            res_inf = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_sequencer.sv
// Issue/capture controller for an external floating-point adder: accepts an operand pair,
// pulses go, waits the adder latency and holds the registered result on a valid/ready output.
module fp_add_sequencer #(
    parameter int ADDER_LATENCY = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        in_sub,
    output logic [31:0] addend_a,
    output logic [31:0] addend_b,
    output logic        go,
    input  logic [31:0] result,
    input  logic        zero,
    input  logic        inf,
    input  logic        nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_inf,
    output logic        out_nan
);
    import fp_add_sequencer_pkg::*;

    localparam int CW = (ADDER_LATENCY > 0) ? $clog2(ADDER_LATENCY + 1) : 1;
    localparam logic [CW-1:0] CNT_LOAD = (ADDER_LATENCY > 0) ? CW'(ADDER_LATENCY - 1) : CW'(0);

    if (ADDER_LATENCY < 0) begin : g_bad_latency
        $error("fp_add_sequencer: ADDER_LATENCY must be >= 0");
    end

    seq_state_t    state_reg, state_next;
    logic [CW-1:0] count_reg;
    logic [31:0]   addend_a_reg, addend_b_reg;
    logic [31:0]   out_result_reg;
    logic          out_zero_reg, out_inf_reg, out_nan_reg;

    logic          accept, capture_adder, load_bypass;
    logic          byp, byp_inf, byp_nan;
    logic [31:0]   byp_result;

    // Special-case resolution runs on the registered (sign-fixed) operands during ISSUE
    fp_special_resolve u_resolve (
        .a       (addend_a_reg),
        .b       (addend_b_reg),
        .bypass  (byp),
        .result  (byp_result),
        .res_inf (byp_inf),
        .res_nan (byp_nan)
    );

    assign in_ready = (state_reg == SEQ_IDLE) && !reset;

    always_comb begin
        state_next    = state_reg;
        go            = 1'b0;
        accept        = 1'b0;
        capture_adder = 1'b0;
        load_bypass   = 1'b0;
        case (state_reg)
            SEQ_IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    state_next = SEQ_ISSUE;
                end
            end
            SEQ_ISSUE: begin
                if (byp) begin
                    load_bypass = 1'b1;
                    state_next  = SEQ_DONE;
                end else begin
                    go = 1'b1;
                    if (ADDER_LATENCY == 0) begin
                        capture_adder = 1'b1;
                        state_next    = SEQ_DONE;
                    end else begin
                        state_next = SEQ_WAIT;
                    end
                end
            end
            SEQ_WAIT: begin
                if (count_reg == '0) begin
                    capture_adder = 1'b1;
                    state_next    = SEQ_DONE;
                end
            end
            SEQ_DONE: begin
                if (out_ready) begin
                    state_next = SEQ_IDLE;
                end
            end
            default: state_next = SEQ_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= SEQ_IDLE;
            count_reg      <= '0;
            addend_a_reg   <= '0;
            addend_b_reg   <= '0;
            out_result_reg <= '0;
            out_zero_reg   <= 1'b0;
            out_inf_reg    <= 1'b0;
            out_nan_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                addend_a_reg <= in_a;
                addend_b_reg <= {in_b[31] ^ in_sub, in_b[30:0]};
            end
            if (state_reg == SEQ_ISSUE && !byp) begin
                count_reg <= CNT_LOAD;
            end else if (state_reg == SEQ_WAIT && count_reg != '0) begin
                count_reg <= count_reg - CW'(1);
            end
            if (capture_adder) begin
                out_result_reg <= result;
                out_zero_reg   <= zero;
                out_inf_reg    <= inf;
                out_nan_reg    <= nan;
            end else if (load_bypass) begin
                out_result_reg <= byp_result;
                out_zero_reg   <= 1'b0;
                out_inf_reg    <= byp_inf;
                out_nan_reg    <= byp_nan;
            end
        end
    end

    assign addend_a   = addend_a_reg;
    assign addend_b   = addend_b_reg;
    assign out_valid  = (state_reg == SEQ_DONE);
    assign out_result = out_result_reg;
    assign out_zero   = out_zero_reg;
    assign out_inf    = out_inf_reg;
    assign out_nan    = out_nan_reg;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Bench for fp_add_sequencer: two instances (adder latency 0 and 3) share the operand stream,
// each driven by a small behavioural adder stub.
module tb_fp_add_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        in_sub;
    logic        out_ready;

    logic        in_ready0, go0, out_valid0, out_zero0, out_inf0, out_nan0;
    logic [31:0] addend_a0, addend_b0, out_result0, result0;
    logic        zero0, inf0, nan0;

    logic        in_ready3, go3, out_valid3, out_zero3, out_inf3, out_nan3;
    logic [31:0] addend_a3, addend_b3, out_result3, result3;
    logic        zero3, inf3, nan3;
    logic [2:0]  vpipe3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clock = ~clock;

    fp_add_sequencer #(.ADDER_LATENCY(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .addend_a(addend_a0), .addend_b(addend_b0), .go(go0),
        .result(result0), .zero(zero0), .inf(inf0), .nan(nan0),
        .out_valid(out_valid0), .out_ready(out_ready), .out_result(out_result0),
        .out_zero(out_zero0), .out_inf(out_inf0), .out_nan(out_nan0)
    );

    fp_add_sequencer #(.ADDER_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready3),
        .in_a(in_a), .in_b(in_b), .in_sub(in_sub),
        .addend_a(addend_a3), .addend_b(addend_b3), .go(go3),
        .result(result3), .zero(zero3), .inf(inf3), .nan(nan3),
        .out_valid(out_valid3), .out_ready(out_ready), .out_result(out_result3),
        .out_zero(out_zero3), .out_inf(out_inf3), .out_nan(out_nan3)
    );

    // Adder stub: knows only the sums the vectors need; garbage when not valid
    function automatic logic [31:0] add_model(input logic [31:0] a, input logic [31:0] b);
        if (a == (b ^ 32'h80000000)) return 32'h00000000;
        if (a == b) return {a[31], a[30:23] + 8'd1, a[22:0]};
        if ((a == 32'h3F800000 && b == 32'h40000000) || (a == 32'h40000000 && b == 32'h3F800000))
            return 32'h40400000;
        return 32'hBAD0BAD0;
    endfunction

    always @(posedge clock) begin
        if (reset) vpipe3 <= 3'b000;
        else       vpipe3 <= {vpipe3[1:0], go3};
    end

    assign result0 = go0 ? add_model(addend_a0, addend_b0) : 32'hDEADBEEF;
    assign zero0   = go0 && (result0[30:0] == 31'd0);
    assign inf0    = go0 && (result0[30:23] == 8'hFF) && (result0[22:0] == 23'd0);
    assign nan0    = go0 && (result0[30:23] == 8'hFF) && (result0[22:0] != 23'd0);
    assign result3 = vpipe3[2] ? add_model(addend_a3, addend_b3) : 32'hDEADBEEF;
    assign zero3   = vpipe3[2] && (result3[30:0] == 31'd0);
    assign inf3    = vpipe3[2] && (result3[30:23] == 8'hFF) && (result3[22:0] == 23'd0);
    assign nan3    = vpipe3[2] && (result3[30:23] == 8'hFF) && (result3[22:0] != 23'd0);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] res;
        logic        z;
        logic        i;
        logic        n;
        logic        byp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        total_cnt++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else             pass_cnt++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready0 && in_ready3) && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!(in_ready0 && in_ready3)) check("wait_idle", {in_ready0, in_ready3}, 2'b11);
    endtask

    task automatic run_op(input int idx, input vec_t v);
        int lat0 = -1, lat3 = -1, go0n = 0, go3n = 0, stab3 = 0;
        logic [34:0] got0 = '0, got3 = '0;
        logic [31:0] expb;
        expb = {v.b[31] ^ v.sub, v.b[30:0]};
        wait_idle();
        in_a = v.a; in_b = v.b; in_sub = v.sub; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0; in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_sub = ~v.sub;
        for (int c = 0; c < 20 && (lat0 < 0 || lat3 < 0); c++) begin
            if (c > 0) @(posedge clock);
            @(negedge clock);
            if (lat0 < 0) begin
                if (out_valid0) begin
                    lat0 = c;
                    got0 = {out_result0, out_zero0, out_inf0, out_nan0};
                end else go0n += int'(go0);
            end
            if (lat3 < 0) begin
                if (out_valid3) begin
                    lat3 = c;
                    got3 = {out_result3, out_zero3, out_inf3, out_nan3};
                end else begin
                    go3n += int'(go3);
                    if (addend_a3 == v.a && addend_b3 == expb) stab3++;
                end
            end
        end
        check($sformatf("v%0d_res_l0", idx), 128'(got0), 128'({v.res, v.z, v.i, v.n}));
        check($sformatf("v%0d_res_l3", idx), 128'(got3), 128'({v.res, v.z, v.i, v.n}));
        check($sformatf("v%0d_lat_l0", idx), 128'(lat0), 128'(1));
        check($sformatf("v%0d_lat_l3", idx), 128'(lat3), v.byp ? 128'(1) : 128'(4));
        check($sformatf("v%0d_go_l0", idx), 128'(go0n), v.byp ? 128'(0) : 128'(1));
        check($sformatf("v%0d_go_l3", idx), 128'(go3n), v.byp ? 128'(0) : 128'(1));
        check($sformatf("v%0d_addend_l3", idx), 128'(stab3), v.byp ? 128'(1) : 128'(4));
        $display("op %0d: a=%h b=%h sub=%0d -> l0 %h lat %0d, l3 %h lat %0d",
                 idx, v.a, v.b, v.sub, got0[34:3], lat0, got3[34:3], lat3);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         a             b             sub   res           z     i     n     byp
        vecs[0] = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{32'h7F800000, 32'h7F800000, 1'b0, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{32'h7FA00000, 32'h3F800000, 1'b0, 32'h7FC00000, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[9] = '{32'h40000000, 32'hBF800000, 1'b1, 32'h40400000, 1'b0, 1'b0, 1'b0, 1'b0};

        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sub = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_l0", 128'({in_ready0, out_valid0, go0, addend_a0, addend_b0, out_result0,
                                out_zero0, out_inf0, out_nan0}), 128'(0));
        check("reset_l3", 128'({in_ready3, out_valid3, go3, addend_a3, addend_b3, out_result3,
                                out_zero3, out_inf3, out_nan3}), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", 128'({in_ready0, in_ready3}), 128'(2'b11));

        for (int i = 0; i < 10; i++) run_op(i, vecs[i]);

        // Backpressure: hold DONE for 5 cycles while a second operand is offered
        wait_idle();
        out_ready = 1'b0;
        in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_a = 32'h40000000; in_b = 32'h40000000;
        begin
            int n = 0;
            @(negedge clock);
            while (!out_valid3 && n < 20) begin
                @(negedge clock);
                n++;
            end
        end
        for (int c = 0; c < 5; c++) begin
            check($sformatf("hold_l0_c%0d", c), 128'({out_valid0, out_result0, in_ready0, go0}),
                  128'({1'b1, 32'h40400000, 1'b0, 1'b0}));
            check($sformatf("hold_l3_c%0d", c), 128'({out_valid3, out_result3, in_ready3, go3}),
                  128'({1'b1, 32'h40400000, 1'b0, 1'b0}));
            $display("hold cycle %0d: l0 valid=%0d %h, l3 valid=%0d %h",
                     c, out_valid0, out_result0, out_valid3, out_result3);
            @(negedge clock);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        check("release", 128'({out_valid0, in_ready0, out_valid3, in_ready3}), 128'(4'b0101));
        check("release_addend", 128'({addend_a3, addend_b3}), 128'({32'h3F800000, 32'h40000000}));

        // Reset while the latency-3 instance is waiting on the adder
        wait_idle();
        in_a = 32'h3F800000; in_b = 32'h40000000; in_sub = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_wait_l3", 128'({out_valid3, go3, in_ready3, addend_a3, addend_b3, out_result3}), 128'(0));
        $display("reset in WAIT: valid=%0d go=%0d result=%h", out_valid3, go3, out_result3);
        reset = 1'b0;
        @(negedge clock);
        check("rst_wait_idle", 128'({in_ready3, out_valid3}), 128'(2'b10));
        run_op(10, vecs[0]);
        run_op(11, vecs[1]);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
